dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_BYTES, default 1024, byte capacity of storage; power of two.
REQ-002 Parameter LATENCY, default 2, wait cycles between request acceptance and response; range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-low.
REQ-005 req_valid  input  1  CPU MEM-stage request present.
REQ-006 req_ready  output  1  responder able to accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  64  byte address.
REQ-009 req_wdata  input  64  store data, right-justified.
REQ-010 req_size  input  4  transfer size in bytes (1, 2, 4 or 8).
REQ-011 resp_valid  output  1  one-cycle response strobe.
REQ-012 resp_rdata  output  64  load data, zero-extended; 0 for stores.
REQ-013 resp_err  output  1  access error flag; constant 0 when DMEM_ALIGN_CHECK_EN is undefined.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted on a cycle with req_valid=1 and req_ready=1; write, addr, wdata and size are then registered, and later input changes are ignored.
REQ-017 On acceptance the FSM SHALL go to WAIT with a down-counter loaded with LATENCY; with LATENCY=0 it goes directly to RESP.
REQ-018 In WAIT the counter SHALL decrement each cycle; on the cycle it reads 1, the next state is RESP.
REQ-019 In RESP, resp_valid SHALL be 1 for exactly one cycle, and the next state is IDLE.
REQ-020 Latency from the accepting edge to resp_valid high SHALL be LATENCY+1 cycles; the next request can be accepted at the earliest LATENCY+2 cycles after the previous one.
REQ-021 A store SHALL commit req_size bytes on the edge entering RESP.
REQ-022 Byte order SHALL be big-endian: the byte at addr receives wdata[8*size-1 : 8*size-8].
REQ-023 A load SHALL sample storage on the edge entering RESP; resp_rdata holds the zero-extended value only while resp_valid=1 and is 0 otherwise.
REQ-024 Byte addresses SHALL wrap modulo DEPTH_BYTES, including within a multi-byte access that crosses the top of storage.
REQ-025 A req_size other than 1, 2, 4 or 8 SHALL make the access a no-op: no write, resp_rdata 0, and resp_err 1 when the check is enabled.
REQ-026 req_valid asserted in WAIT or RESP SHALL be ignored and produce no side effect.

Reset
REQ-027 While rst=0 at a clock edge: state goes to IDLE, the counter to 0, and resp_valid, resp_rdata and resp_err to 0.
REQ-028 A reset during WAIT SHALL abandon the access: no store commit and no response.
REQ-029 Storage contents SHALL NOT be cleared by reset.
REQ-030 req_ready SHALL be 0 while rst=0 and 1 on the first cycle after reset is released.

Configuration
REQ-031 With macro DMEM_ALIGN_CHECK_EN defined, an access whose addr is not a multiple of req_size SHALL be a no-op (no write, rdata 0) and respond with resp_err=1 at normal latency.
REQ-032 With DMEM_ALIGN_CHECK_EN undefined, misaligned accesses SHALL complete normally and resp_err SHALL be tied to 0.

Structure
REQ-033 Package dmem_pkg SHALL hold the state enum, the legal size constants (1, 2, 4, 8) and the LATENCY counter width (4).
REQ-034 The storage SHALL be a sub-module dmem_byte_array: DEPTH_BYTES x 8 bits, one 8-byte write port with per-byte enables, and one 8-byte read port, both with wrapped addressing.

Verification
REQ-035 Reset then release: req_ready=1, resp_valid=0, resp_rdata=0.
REQ-036 LATENCY=2: store size 8, addr 0x10, data 0x0123456789ABCDEF; then load size 8, addr 0x10 -> resp_valid exactly 3 cycles after each acceptance, load rdata 0x0123456789ABCDEF.
REQ-037 After REQ-036, load size 1 at addr 0x10 -> rdata 0x01; load size 2 at addr 0x16 -> rdata 0xCDEF.
REQ-038 DEPTH_BYTES=1024: store size 4, addr 0x3FE, data 0xAABBCCDD; load size 1 at 0x000 -> 0xCC; load size 1 at 0x001 -> 0xDD.
REQ-039 Assert rst=0 one cycle into WAIT of a store to 0x20, then load 0x20 -> old contents unchanged and no resp_valid for the aborted store.
REQ-040 DMEM_ALIGN_CHECK_EN defined: load size 4 at addr 0x12 -> resp_err=1, rdata 0; undefined: same access returns stored data with resp_err=0. Also, size 3 -> no write, rdata 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, legal
// transfer sizes, wait-counter width and small access-check helpers.
package dmem_pkg;

   localparam int CNT_W = 4;

   localparam logic [3:0] SIZE_B = 4'd1;
   localparam logic [3:0] SIZE_H = 4'd2;
   localparam logic [3:0] SIZE_W = 4'd4;
   localparam logic [3:0] SIZE_D = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // True for the four transfer sizes the responder services.
   function automatic logic size_legal(input logic [3:0] size);
      return (size == SIZE_B) || (size == SIZE_H) ||
             (size == SIZE_W) || (size == SIZE_D);
   endfunction

   // True when a legal-size access does not start on a size boundary.
   // size[2:0]-1 gives the alignment mask (size 8 wraps to 3'b111).
   function automatic logic misaligned(input logic [2:0] addr_lo,
                                       input logic [3:0] size);
      return (addr_lo & (size[2:0] - 3'd1)) != 3'd0;
   endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-addressed storage, DEPTH_BYTES x 8. One 8-lane write port with
// per-lane enables and one 8-lane registered read port. Lane k always
// maps to byte address (addr + k) modulo DEPTH_BYTES, so multi-byte
// accesses wrap cleanly across the top of storage. DEPTH_BYTES >= 8.
module dmem_byte_array #(
   parameter int DEPTH_BYTES = 1024,
   localparam int AW = $clog2(DEPTH_BYTES)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [63:0]   wr_data,
   input  logic [7:0]    wr_be,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [63:0]   rd_data
);

   logic [7:0]    mem [DEPTH_BYTES];
   logic [AW-1:0] wr_lane_addr [8];
   logic [AW-1:0] rd_lane_addr [8];
   logic [63:0]   rd_data_reg;

   // Per-lane byte addresses; the AW-bit add provides the wrap.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         assign wr_lane_addr[gi] = wr_addr + AW'(gi);
         assign rd_lane_addr[gi] = rd_addr + AW'(gi);
      end
   endgenerate

   // Commit enabled write lanes.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < 8; k++) begin
            if (wr_be[k]) begin
               mem[wr_lane_addr[k]] <= wr_data[8*k +: 8];
            end
         end
      end
   end

   // Registered read of all eight lanes.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         for (int k = 0; k < 8; k++) begin
            rd_data_reg[8*k +: 8] <= mem[rd_lane_addr[k]];
         end
      end
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/dmem_responder.sv
// CPU MEM-stage data-memory responder with a fixed, parameterised wait
// latency. Big-endian byte ordering, addresses wrap modulo DEPTH_BYTES.
// Optional build macro DMEM_ALIGN_CHECK_EN: misaligned accesses become
// no-ops that respond with resp_err=1. Without it resp_err is tied to 0.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_BYTES = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [3:0]  req_size,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH_BYTES);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   logic             write_reg;
   logic [AW-1:0]    addr_reg;
   logic [63:0]      wdata_reg;
   logic [3:0]       size_reg;

   logic             accept;
   logic             enter_resp;
   logic             cur_write;
   logic [AW-1:0]    cur_addr;
   logic [63:0]      cur_wdata;
   logic [3:0]       cur_size;
   logic             cur_fault;
   logic             resp_fault;

   logic [6:0]       wr_shift;
   logic [6:0]       rd_shift;
   logic [63:0]      wdata_lj;
   logic [63:0]      wr_lanes;
   logic [7:0]       wr_be;
   logic             wr_en;
   logic [63:0]      rd_data;
   logic [63:0]      rd_lj;

   // Upper address bits are discarded: storage wraps modulo DEPTH_BYTES.
   logic             unused_addr_bits;
   assign unused_addr_bits = ^req_addr[63:AW];

   assign req_ready = rst && (state_reg == ST_IDLE);
   assign accept    = req_valid && req_ready;

   // State and wait-counter register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               if (LATENCY == 0) begin
                  state_next = ST_RESP;
               end else begin
                  state_next = ST_WAIT;
                  cnt_next   = CNT_W'(LATENCY);
               end
            end
         end
         ST_WAIT: begin
            cnt_next = cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Capture the request fields at acceptance; later input changes are ignored.
   always_ff @(posedge clk) begin
      if (accept) begin
         write_reg <= req_write;
         addr_reg  <= req_addr[AW-1:0];
         wdata_reg <= req_wdata;
         size_reg  <= req_size;
      end
   end

   // With LATENCY=0 the commit edge is the acceptance edge itself, so the
   // live request is used while still in IDLE.
   assign cur_write = (state_reg == ST_IDLE) ? req_write         : write_reg;
   assign cur_addr  = (state_reg == ST_IDLE) ? req_addr[AW-1:0]  : addr_reg;
   assign cur_wdata = (state_reg == ST_IDLE) ? req_wdata         : wdata_reg;
   assign cur_size  = (state_reg == ST_IDLE) ? req_size          : size_reg;

`ifdef DMEM_ALIGN_CHECK_EN
   assign cur_fault  = !size_legal(cur_size) || misaligned(cur_addr[2:0], cur_size);
   assign resp_fault = !size_legal(size_reg) || misaligned(addr_reg[2:0], size_reg);
`else
   assign cur_fault  = !size_legal(cur_size);
   assign resp_fault = !size_legal(size_reg);
`endif

   assign enter_resp = rst && (state_next == ST_RESP);

   // Left-justify store data so its most significant byte sits on lane 0.
   assign wr_shift = 7'd64 - {cur_size, 3'b000};
   assign wdata_lj = cur_wdata << wr_shift;
   assign wr_en    = enter_resp && cur_write && !cur_fault;

   // Lane permutation between big-endian value order and address order.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_be
         assign wr_lanes[8*gi +: 8]     = wdata_lj[63-8*gi -: 8];
         assign wr_be[gi]               = (4'(gi) < cur_size);
         assign rd_lj[63-8*gi -: 8]     = rd_data[8*gi +: 8];
      end
   endgenerate

   dmem_byte_array #(
      .DEPTH_BYTES (DEPTH_BYTES)
   ) u_array (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (cur_addr),
      .wr_data (wr_lanes),
      .wr_be   (wr_be),
      .rd_en   (enter_resp),
      .rd_addr (cur_addr),
      .rd_data (rd_data)
   );

   // Right-justify the loaded bytes; zero outside a valid load response.
   assign rd_shift   = 7'd64 - {size_reg, 3'b000};
   assign resp_valid = (state_reg == ST_RESP);
   assign resp_rdata = (resp_valid && !write_reg && !resp_fault) ? (rd_lj >> rd_shift) : 64'd0;

`ifdef DMEM_ALIGN_CHECK_EN
   assign resp_err = resp_valid && resp_fault;
`else
   assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH_BYTES=1024, LATENCY=2):
// directed vector table, reset-abort sequence and randomized traffic
// checked against a byte-array reference model.
module tb_dmem_responder;

   localparam int DEPTH = 1024;
   localparam int LAT   = 2;
`ifdef DMEM_ALIGN_CHECK_EN
   localparam logic ALIGN_EN = 1'b1;
`else
   localparam logic ALIGN_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [3:0]  req_size;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;

   int checks = 0;
   int errors = 0;

   logic [7:0] mdl [DEPTH];

   typedef struct {
      logic        w;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [3:0]  size;
      logic [63:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [12];

   dmem_responder #(
      .DEPTH_BYTES (DEPTH),
      .LATENCY     (LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_size   (req_size),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: bytes stored big-endian from addr upward, wrapping.
   function automatic void model_access(input logic w, input logic [63:0] a,
                                        input logic [63:0] d, input logic [3:0] s,
                                        output logic [63:0] rd, output logic er);
      int  sz;
      bit  legal;
      bit  mis;
      bit  fault;
      sz    = int'(s);
      legal = (sz == 1) || (sz == 2) || (sz == 4) || (sz == 8);
      mis   = legal && ((a % 64'(sz)) != 0);
      fault = !legal || (ALIGN_EN && mis);
      er    = ALIGN_EN && fault;
      rd    = 64'd0;
      if (!fault) begin
         for (int k = 0; k < sz; k++) begin
            int idx;
            idx = int'((a + 64'(k)) % 64'(DEPTH));
            if (w) mdl[idx] = d[8*(sz-1-k) +: 8];
            else   rd = (rd << 8) | 64'(mdl[idx]);
         end
      end
   endfunction

   // One request; starts and ends at a negedge. Inputs are scrambled while
   // the responder is busy to confirm they are ignored.
   task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                         input logic [3:0] s, output logic [63:0] rd,
                         output logic er, output int lat);
      int n;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_size  = s;
      @(posedge clk);
      @(negedge clk);
      lat       = 1;
      req_write = 1'b1;
      req_addr  = 64'($urandom_range(0, DEPTH-1));
      req_wdata = {$urandom, $urandom};
      req_size  = 4'd8;
      while (!resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rd = resp_rdata;
      er = resp_err;
      req_valid = 1'b0;
      @(negedge clk);
      check("pulse_len", 64'(resp_valid), 64'd0);
      check("rdata_idle", resp_rdata, 64'd0);
      check("ready_next", 64'(req_ready), 64'd1);
   endtask

   initial begin
      logic [63:0] rd, exp_rd, wd;
      logic        er, exp_er;
      int          lat;
      int          cnt;
      logic [63:0] a;
      logic [3:0]  s;
      logic        w;
      logic [3:0]  sizes [10];

      sizes = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd0};

      vecs[0]  = '{1'b1, 64'h10,  64'h0123456789ABCDEF, 4'd8, 64'd0, 1'b0};
      vecs[1]  = '{1'b0, 64'h10,  64'd0,                4'd8, 64'h0123456789ABCDEF, 1'b0};
      vecs[2]  = '{1'b0, 64'h10,  64'd0,                4'd1, 64'h01, 1'b0};
      vecs[3]  = '{1'b0, 64'h16,  64'd0,                4'd2, 64'hCDEF, 1'b0};
      vecs[4]  = '{1'b1, 64'h3FE, 64'hAABBCCDD,         4'd4, 64'd0, 1'b0};
      vecs[5]  = '{1'b0, 64'h0,   64'd0,                4'd1, 64'hCC, 1'b0};
      vecs[6]  = '{1'b0, 64'h1,   64'd0,                4'd1, 64'hDD, 1'b0};
      vecs[7]  = '{1'b0, 64'h3FE, 64'd0,                4'd1, 64'hAA, 1'b0};
      vecs[8]  = '{1'b0, 64'h12,  64'd0,                4'd4, (ALIGN_EN ? 64'd0 : 64'h456789AB), ALIGN_EN};
      vecs[9]  = '{1'b1, 64'h10,  64'hFFFFFF,           4'd3, 64'd0, ALIGN_EN};
      vecs[10] = '{1'b0, 64'h10,  64'd0,                4'd8, 64'h0123456789ABCDEF, 1'b0};
      vecs[11] = '{1'b0, 64'h10,  64'd0,                4'd3, 64'd0, ALIGN_EN};

      rst = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; req_size = 4'd8;
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_valid", 64'(resp_valid), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 64'(req_ready), 64'd1);
      check("post_rst_valid", 64'(resp_valid), 64'd0);
      check("post_rst_rdata", resp_rdata, 64'd0);

      // Fill storage with known contents.
      for (int i = 0; i < DEPTH/8; i++) begin
         wd = {$urandom, $urandom};
         model_access(1'b1, 64'(i*8), wd, 4'd8, exp_rd, exp_er);
         do_req(1'b1, 64'(i*8), wd, 4'd8, rd, er, lat);
         check("init_lat", 64'(lat), 64'(LAT+1));
      end
      $display("init: %0d stores done", DEPTH/8);

      // Directed vectors.
      for (int i = 0; i < 12; i++) begin
         model_access(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].size, exp_rd, exp_er);
         do_req(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].size, rd, er, lat);
         $display("vec %0d w=%0b addr=%h size=%0d rdata=%h err=%0b lat=%0d",
                  i, vecs[i].w, vecs[i].addr, vecs[i].size, rd, er, lat);
         check($sformatf("vec%0d_lat", i), 64'(lat), 64'(LAT+1));
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
      end

      // Reset one cycle into WAIT of a store: store abandoned, no response.
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20;
      req_wdata = 64'hDEADBEEFCAFEF00D; req_size = 4'd8;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("abort_ready", 64'(req_ready), 64'd0);
      rst = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (resp_valid) cnt++;
         @(negedge clk);
      end
      check("abort_noresp", 64'(cnt), 64'd0);
      model_access(1'b0, 64'h20, 64'd0, 4'd8, exp_rd, exp_er);
      do_req(1'b0, 64'h20, 64'd0, 4'd8, rd, er, lat);
      $display("abort: load addr=20 rdata=%h", rd);
      check("abort_rdata", rd, exp_rd);

      // Randomized traffic against the model.
      for (int i = 0; i < 300; i++) begin
         s = sizes[$urandom_range(0, 9)];
         a = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, DEPTH-1));
         if ($urandom_range(0, 1) == 1 && (s == 4'd2 || s == 4'd4 || s == 4'd8))
            a = a & ~(64'(s) - 64'd1);
         w  = 1'($urandom_range(0, 1));
         wd = {$urandom, $urandom};
         model_access(w, a, wd, s, exp_rd, exp_er);
         do_req(w, a, wd, s, rd, er, lat);
         $display("rnd %0d w=%0b addr=%h size=%0d rdata=%h err=%0b", i, w, a, s, rd, er);
         check("rnd_lat", 64'(lat), 64'(LAT+1));
         check("rnd_rdata", rd, exp_rd);
         check("rnd_err", 64'(er), 64'(exp_er));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
